// File: rtl/ac97_codec_responder.sv
// Codec-side AC'97 link endpoint: decodes SYNC/SDATA_OUT frames, runs register
// reads/writes, presents DAC samples and serializes tag, read response and ADC data.
module ac97_codec_responder #(
  parameter int          CODEC_READY_FRAMES = 4,
  parameter logic [15:0] VENDOR_ID1         = 16'h4E53,
  parameter logic [15:0] VENDOR_ID2         = 16'h4350
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        SYNC,
  input  logic        SDATA_OUT,
  output logic        SDATA_IN,
  input  logic [17:0] adc_left,
  input  logic [17:0] adc_right,
  output logic        adc_sample,
  output logic [17:0] dac_left,
  output logic [17:0] dac_right,
  output logic        dac_valid,
  output logic        codec_ready,
  output logic        frame_error
);

  logic        sync_q;
  logic [7:0]  bit_cnt;
  logic        sync_rise;
  logic        active;
  logic        commit;
  logic [7:0]  idx;

  logic [15:0] tag_sr;
  logic [19:0] s1_sr, s2_sr, s3_sr, s4_sr;

  logic [17:0] adc_l_q, adc_r_q;
  logic [15:0] frame_cnt;
  logic        rd_pend;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data_q;

  logic [15:0] regs [64];
  logic [15:0] rd_data;
  logic [5:0]  cmd_idx;
  logic        frame_ok, do_write, do_read, do_dac;

  logic [15:0] tx_tag;
  logic [19:0] tx_word;
  logic [4:0]  tx_rel;
  logic        tx_bit;
  logic        unused_bits;

  // bit_cnt holds the index of the out-frame bit sampled on the last edge;
  // idx is the index of the bit being sampled on the coming edge.
  assign sync_rise = SYNC & ~sync_q;
  assign active    = sync_rise | (bit_cnt != 8'hFF);
  assign idx       = sync_rise ? 8'd0 : bit_cnt + 8'd1;
  assign commit    = ~sync_rise & (bit_cnt == 8'd254);

  assign cmd_idx  = s1_sr[18:13];
  assign frame_ok = tag_sr[15] & codec_ready;
  assign do_write = commit & frame_ok & tag_sr[14] & tag_sr[13] & ~s1_sr[19];
  assign do_read  = commit & frame_ok & tag_sr[14] & s1_sr[19];
  assign do_dac   = commit & frame_ok & tag_sr[12];

  assign unused_bits = ^{tag_sr[11:0], s1_sr[11:0], s2_sr[3:0], s3_sr[1:0], s4_sr[1:0]};

  function automatic logic [15:0] reg_default(input int i);
    case (i)
      1:       reg_default = 16'h8000;
      12:      reg_default = 16'h8808;
      default: reg_default = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 1'b0;
      bit_cnt     <= 8'hFF;
      frame_error <= 1'b0;
      adc_sample  <= 1'b0;
      adc_l_q     <= '0;
      adc_r_q     <= '0;
    end else begin
      sync_q      <= SYNC;
      frame_error <= sync_rise & (bit_cnt != 8'hFF);
      adc_sample  <= sync_rise;
      if (sync_rise) begin
        bit_cnt <= 8'd0;
        adc_l_q <= adc_left;
        adc_r_q <= adc_right;
      end else if (bit_cnt != 8'hFF) begin
        bit_cnt <= bit_cnt + 8'd1;
      end
    end
  end

  // Every field is fully reshifted within its slot, so no clear at frame start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_sr <= '0;
      s1_sr  <= '0;
      s2_sr  <= '0;
      s3_sr  <= '0;
      s4_sr  <= '0;
    end else if (active) begin
      if (idx < 8'd16)      tag_sr <= {tag_sr[14:0], SDATA_OUT};
      else if (idx < 8'd36) s1_sr  <= {s1_sr[18:0], SDATA_OUT};
      else if (idx < 8'd56) s2_sr  <= {s2_sr[18:0], SDATA_OUT};
      else if (idx < 8'd76) s3_sr  <= {s3_sr[18:0], SDATA_OUT};
      else if (idx < 8'd96) s4_sr  <= {s4_sr[18:0], SDATA_OUT};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) regs[i] <= reg_default(i);
    end else if (do_write) begin
      if (cmd_idx == 6'd0) begin
        for (int i = 0; i < 64; i++) regs[i] <= reg_default(i);
      end else if (cmd_idx != 6'h3E && cmd_idx != 6'h3F) begin
        regs[cmd_idx] <= s2_sr[19:4];
      end
    end
  end

  always_comb begin
    rd_data = regs[cmd_idx];
    case (cmd_idx)
      6'h13:   rd_data = {regs[cmd_idx][15:4], 4'hF};
      6'h3E:   rd_data = VENDOR_ID1;
      6'h3F:   rd_data = VENDOR_ID2;
      default: rd_data = regs[cmd_idx];
    endcase
  end

  // End-of-frame bookkeeping: readiness, read response and DAC update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      codec_ready <= 1'b0;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      rd_data_q   <= '0;
      dac_left    <= '0;
      dac_right   <= '0;
      dac_valid   <= 1'b0;
    end else begin
      dac_valid <= do_dac;
      if (commit) begin
        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
        if (int'(frame_cnt) + 1 >= CODEC_READY_FRAMES) codec_ready <= 1'b1;
        rd_pend <= do_read;
        if (do_read) begin
          rd_addr   <= s1_sr[18:12];
          rd_data_q <= rd_data;
        end
      end
      if (do_dac) begin
        dac_left  <= s3_sr[19:2];
        dac_right <= s4_sr[19:2];
      end
    end
  end

  assign tx_tag = codec_ready ? {1'b1, rd_pend, rd_pend, 2'b11, 11'b0} : 16'h0000;

  always_comb begin
    tx_word = '0;
    tx_rel  = '0;
    if (idx < 8'd16) begin
      tx_word = {tx_tag, 4'b0};
      tx_rel  = idx[4:0];
    end else if (idx < 8'd36) begin
      tx_word = rd_pend ? {1'b0, rd_addr, 12'b0} : 20'h0;
      tx_rel  = 5'(idx - 8'd16);
    end else if (idx < 8'd56) begin
      tx_word = rd_pend ? {rd_data_q, 4'b0} : 20'h0;
      tx_rel  = 5'(idx - 8'd36);
    end else if (idx < 8'd76) begin
      tx_word = codec_ready ? {adc_l_q, 2'b00} : 20'h0;
      tx_rel  = 5'(idx - 8'd56);
    end else if (idx < 8'd96) begin
      tx_word = codec_ready ? {adc_r_q, 2'b00} : 20'h0;
      tx_rel  = 5'(idx - 8'd76);
    end
    tx_bit = tx_word[5'd19 - tx_rel];
  end

  // In-frame bit k leaves the register one cycle after out-frame bit k is sampled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) SDATA_IN <= 1'b0;
    else          SDATA_IN <= active & tx_bit;
  end

endmodule

// File: tb/tb_ac97_codec_responder.sv
// Directed bench for ac97_codec_responder: table of whole frames with expected
// in-frame response, plus abort and mid-frame reset sequences.
module tb_ac97_codec_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        SYNC;
  logic        SDATA_OUT;
  logic        SDATA_IN;
  logic [17:0] adc_left, adc_right;
  logic        adc_sample;
  logic [17:0] dac_left, dac_right;
  logic        dac_valid;
  logic        codec_ready;
  logic        frame_error;

  ac97_codec_responder dut (
    .clock(clock), .reset_n(reset_n), .SYNC(SYNC), .SDATA_OUT(SDATA_OUT),
    .SDATA_IN(SDATA_IN), .adc_left(adc_left), .adc_right(adc_right),
    .adc_sample(adc_sample), .dac_left(dac_left), .dac_right(dac_right),
    .dac_valid(dac_valid), .codec_ready(codec_ready), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] in_frame;
  int dv_cnt, fe_cnt, as_cnt;
  logic last_ready;

  typedef struct {
    logic [15:0] tag;
    logic [19:0] s1, s2, s3, s4;
    logic [15:0] e_tag;
    logic [19:0] e_s1, e_s2;
    logic        e_ready;
    int          e_dv;
    logic [17:0] e_dl, e_dr;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mkv(input logic [15:0] tag, input logic [19:0] s1, s2, s3, s4,
                               input logic [15:0] e_tag, input logic [19:0] e_s1, e_s2,
                               input logic e_ready, input int e_dv,
                               input logic [17:0] e_dl, e_dr);
    vec_t v;
    v.tag = tag; v.s1 = s1; v.s2 = s2; v.s3 = s3; v.s4 = s4;
    v.e_tag = e_tag; v.e_s1 = e_s1; v.e_s2 = e_s2;
    v.e_ready = e_ready; v.e_dv = e_dv; v.e_dl = e_dl; v.e_dr = e_dr;
    return v;
  endfunction

  function automatic logic [255:0] mkf(input logic [15:0] tag, input logic [19:0] s1, s2, s3, s4);
    return {tag, s1, s2, s3, s4, 160'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample_bit(input int k);
    in_frame[255 - k] = SDATA_IN;
    dv_cnt += int'(dac_valid);
    fe_cnt += int'(frame_error);
    as_cnt += int'(adc_sample);
  endtask

  task automatic drive_bits(input logic [255:0] f, input int nbits);
    in_frame = '0;
    dv_cnt = 0; fe_cnt = 0; as_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      @(negedge clock);
      if (b > 0) sample_bit(b - 1);
      SYNC      = (b < 16);
      SDATA_OUT = f[255 - b];
    end
  endtask

  task automatic send_frame(input logic [255:0] f);
    drive_bits(f, 256);
    @(negedge clock);
    sample_bit(255);
    last_ready = codec_ready;
    SYNC = 1'b0;
    SDATA_OUT = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; SYNC = 1'b0; SDATA_OUT = 1'b0;
    adc_left = 18'h2AAAA; adc_right = 18'h15555;

    //           tag      s1        s2        s3        s4        e_tag    e_s1      e_s2     rdy dv  dac_l     dac_r
    vecs[0]  = mkv(16'h8000, 20'h0,     20'h0,     20'h0,     20'h0,     16'h0000, 20'h0,     20'h0,     0, 0, 18'h0,     18'h0);
    vecs[1]  = mkv(16'h8000, 20'h0,     20'h0,     20'h0,     20'h0,     16'h0000, 20'h0,     20'h0,     0, 0, 18'h0,     18'h0);
    vecs[2]  = mkv(16'h8000, 20'h0,     20'h0,     20'h0,     20'h0,     16'h0000, 20'h0,     20'h0,     0, 0, 18'h0,     18'h0);
    vecs[3]  = mkv(16'hE000, 20'h02000, 20'h12340, 20'h0,     20'h0,     16'h0000, 20'h0,     20'h0,     1, 0, 18'h0,     18'h0);
    vecs[4]  = mkv(16'hC000, 20'h82000, 20'h0,     20'h0,     20'h0,     16'h9800, 20'h0,     20'h0,     1, 0, 18'h0,     18'h0);
    vecs[5]  = mkv(16'hE000, 20'h02000, 20'h1F1F0, 20'h0,     20'h0,     16'hF800, 20'h02000, 20'h80000, 1, 0, 18'h0,     18'h0);
    vecs[6]  = mkv(16'hC000, 20'h82000, 20'h0,     20'h0,     20'h0,     16'h9800, 20'h0,     20'h0,     1, 0, 18'h0,     18'h0);
    vecs[7]  = mkv(16'h8000, 20'h0,     20'h0,     20'h0,     20'h0,     16'hF800, 20'h02000, 20'h1F1F0, 1, 0, 18'h0,     18'h0);
    vecs[8]  = mkv(16'hC000, 20'hFC000, 20'h0,     20'h0,     20'h0,     16'h9800, 20'h0,     20'h0,     1, 0, 18'h0,     18'h0);
    vecs[9]  = mkv(16'hC000, 20'hFE000, 20'h0,     20'h0,     20'h0,     16'hF800, 20'h7C000, 20'h4E530, 1, 0, 18'h0,     18'h0);
    vecs[10] = mkv(16'hE000, 20'h7C000, 20'h11110, 20'h0,     20'h0,     16'hF800, 20'h7E000, 20'h43500, 1, 0, 18'h0,     18'h0);
    vecs[11] = mkv(16'hC000, 20'hFC000, 20'h0,     20'h0,     20'h0,     16'h9800, 20'h0,     20'h0,     1, 0, 18'h0,     18'h0);
    vecs[12] = mkv(16'hE000, 20'h26000, 20'hFFF00, 20'h0,     20'h0,     16'hF800, 20'h7C000, 20'h4E530, 1, 0, 18'h0,     18'h0);
    vecs[13] = mkv(16'hC000, 20'hA6000, 20'h0,     20'h0,     20'h0,     16'h9800, 20'h0,     20'h0,     1, 0, 18'h0,     18'h0);
    vecs[14] = mkv(16'hE000, 20'h00000, 20'h00000, 20'h0,     20'h0,     16'hF800, 20'h26000, 20'hFFFF0, 1, 0, 18'h0,     18'h0);
    vecs[15] = mkv(16'hC000, 20'h82000, 20'h0,     20'h0,     20'h0,     16'h9800, 20'h0,     20'h0,     1, 0, 18'h0,     18'h0);
    vecs[16] = mkv(16'hC000, 20'h98000, 20'h0,     20'h0,     20'h0,     16'hF800, 20'h02000, 20'h80000, 1, 0, 18'h0,     18'h0);
    vecs[17] = mkv(16'hC000, 20'hA7000, 20'h0,     20'h0,     20'h0,     16'hF800, 20'h18000, 20'h88080, 1, 0, 18'h0,     18'h0);
    vecs[18] = mkv(16'h9800, 20'h0,     20'h0,     20'h12345, 20'hFFFFF, 16'hF800, 20'h27000, 20'h000F0, 1, 1, 18'h048D1, 18'h3FFFF);
    vecs[19] = mkv(16'h8000, 20'h0,     20'h0,     20'h0,     20'h0,     16'h9800, 20'h0,     20'h0,     1, 0, 18'h048D1, 18'h3FFFF);
    vecs[20] = mkv(16'h7800, 20'h02000, 20'h55550, 20'h00004, 20'h00008, 16'h9800, 20'h0,     20'h0,     1, 0, 18'h048D1, 18'h3FFFF);
    vecs[21] = mkv(16'hC000, 20'h82000, 20'h0,     20'h0,     20'h0,     16'h9800, 20'h0,     20'h0,     1, 0, 18'h048D1, 18'h3FFFF);
    vecs[22] = mkv(16'h8000, 20'h0,     20'h0,     20'h0,     20'h0,     16'hF800, 20'h02000, 20'h80000, 1, 0, 18'h048D1, 18'h3FFFF);
    vecs[23] = mkv(16'hC000, 20'h02000, 20'h77770, 20'h0,     20'h0,     16'h9800, 20'h0,     20'h0,     1, 0, 18'h048D1, 18'h3FFFF);
    vecs[24] = mkv(16'hC000, 20'h82000, 20'h0,     20'h0,     20'h0,     16'h9800, 20'h0,     20'h0,     1, 0, 18'h048D1, 18'h3FFFF);
    vecs[25] = mkv(16'h8000, 20'h0,     20'h0,     20'h0,     20'h0,     16'hF800, 20'h02000, 20'h80000, 1, 0, 18'h048D1, 18'h3FFFF);

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_sdata_in", 32'(SDATA_IN), 32'h0);
    check("rst_ready", 32'(codec_ready), 32'h0);
    check("rst_dac_left", 32'(dac_left), 32'h0);
    check("rst_dac_right", 32'(dac_right), 32'h0);
    check("rst_pulses", {29'h0, dac_valid, frame_error, adc_sample}, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_sdata_in", 32'(SDATA_IN), 32'h0);

    for (int i = 0; i < 26; i++) begin
      send_frame(mkf(vecs[i].tag, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].s4));
      check($sformatf("v%0d_tag", i), 32'(in_frame[255:240]), 32'(vecs[i].e_tag));
      check($sformatf("v%0d_slot1", i), 32'(in_frame[239:220]), 32'(vecs[i].e_s1));
      check($sformatf("v%0d_slot2", i), 32'(in_frame[219:200]), 32'(vecs[i].e_s2));
      check($sformatf("v%0d_slot3", i), 32'(in_frame[199:180]), vecs[i].e_tag[15] ? 32'hAAAA8 : 32'h0);
      check($sformatf("v%0d_slot4", i), 32'(in_frame[179:160]), vecs[i].e_tag[15] ? 32'h55554 : 32'h0);
      check($sformatf("v%0d_rest", i), 32'(|in_frame[159:0]), 32'h0);
      check($sformatf("v%0d_ready", i), 32'(last_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_dac_valid_cnt", i), 32'(dv_cnt), 32'(vecs[i].e_dv));
      check($sformatf("v%0d_dac_left", i), 32'(dac_left), 32'(vecs[i].e_dl));
      check($sformatf("v%0d_dac_right", i), 32'(dac_right), 32'(vecs[i].e_dr));
      check($sformatf("v%0d_frame_error_cnt", i), 32'(fe_cnt), 32'h0);
      check($sformatf("v%0d_adc_sample_cnt", i), 32'(as_cnt), 32'h1);
    end

    // Aborted write frame must not commit
    send_frame(mkf(16'hE000, 20'h02000, 20'h1F1F0, 20'h0, 20'h0));
    drive_bits(mkf(16'hE000, 20'h02000, 20'h00000, 20'h0, 20'h0), 100);
    send_frame(mkf(16'hC000, 20'h82000, 20'h0, 20'h0, 20'h0));
    check("abort_frame_error_cnt", 32'(fe_cnt), 32'h1);
    check("abort_ready_kept", 32'(last_ready), 32'h1);
    send_frame(mkf(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0));
    check("abort_tag", 32'(in_frame[255:240]), 32'hF800);
    check("abort_slot1", 32'(in_frame[239:220]), 32'h02000);
    check("abort_slot2", 32'(in_frame[219:200]), 32'h1F1F0);
    check("abort_frame_error_quiet", 32'(fe_cnt), 32'h0);

    // Reset in the middle of slot 3 (in-bit 58 of 0xAAAA8 is 1)
    drive_bits(mkf(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0), 59);
    @(negedge clock);
    check("pre_reset_sdata_in", 32'(SDATA_IN), 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_sdata_in", 32'(SDATA_IN), 32'h0);
    check("midrst_ready", 32'(codec_ready), 32'h0);
    check("midrst_dac_left", 32'(dac_left), 32'h0);
    check("midrst_dac_right", 32'(dac_right), 32'h0);
    SYNC = 1'b0; SDATA_OUT = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      send_frame(mkf(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0));
      check($sformatf("rerdy_f%0d_ready", i), 32'(last_ready), (i == 3) ? 32'h1 : 32'h0);
    end
    send_frame(mkf(16'hC000, 20'h82000, 20'h0, 20'h0, 20'h0));
    check("rerdy_tag", 32'(in_frame[255:240]), 32'h9800);
    send_frame(mkf(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0));
    check("rerdy_rd_tag", 32'(in_frame[255:240]), 32'hF800);
    check("rerdy_rd_slot1", 32'(in_frame[239:220]), 32'h02000);
    check("rerdy_rd_slot2", 32'(in_frame[219:200]), 32'h80000);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ac97_codec_responder.md
Name: ac97_codec_responder

Overview:
- Synthesizable codec-side AC'97 link endpoint. It is the far end of the LM4550 controller link and is used in place of the external LM4550 for closed-loop simulation and on-FPGA loopback.
- Consumes SYNC/SDATA_OUT frames and executes the register-write and register-read commands they carry.
- Presents DAC PCM samples from slots 3/4.
- Serializes SDATA_IN frames carrying the tag, the read response and ADC PCM.
- Clocked by the bit clock (12.288 MHz).

Parameters:
- CODEC_READY_FRAMES, 4: complete frames after reset before the codec reports ready.
- VENDOR_ID1, 16'h4E53: read-only value of register 0x7C.
- VENDOR_ID2, 16'h4350: read-only value of register 0x7E.

Ports:
- clock  in  1  bit clock; all logic on rising edge.
- reset_n  in  1  asynchronous reset, active low.
- SYNC  in  1  frame sync from controller.
- SDATA_OUT  in  1  serial stream from controller.
- SDATA_IN  out  1  serial stream to controller, registered.
- adc_left  in  18  ADC sample returned in slot 3.
- adc_right  in  18  ADC sample returned in slot 4.
- adc_sample  out  1  one-cycle pulse when adc_left/adc_right are latched.
- dac_left  out  18  last valid slot-3 sample, bits [19:2].
- dac_right  out  18  last valid slot-4 sample, bits [19:2].
- dac_valid  out  1  one-cycle pulse when dac_left/dac_right update.
- codec_ready  out  1  codec-ready flag.
- frame_error  out  1  one-cycle pulse on SYNC restart mid-frame.

Behaviour:
- Reset (reset_n=0): all outputs 0. Bit counter = 255 (idle). Frame counter 0. Read-pending cleared. Register file loaded with defaults.
- Frame format: 256 bits. Slot0 is 16 bits (frame bits 0-15). Slots 1-12 are 20 bits each. Transmission is MSB first.
- Frame start: the cycle where SYNC=1 and the previous sampled SYNC=0 is frame bit 0. The SDATA_OUT value sampled in that cycle is out-frame bit 0, and the bit counter becomes 0.
- Bit counter: increments each cycle and saturates at 255 until the next SYNC rise.
- SDATA_IN timing: in-frame bit k is driven during cycle k+1, i.e. one cycle after out-frame bit k is sampled. SDATA_IN = 0 while idle and for bits of empty slots.
- adc_sample pulses at frame bit 0. adc_left/adc_right are latched into the slot-3/4 shift data at that same cycle.
- Out-frame decode:
  - slot0 bit15 = valid frame; bit14 = slot1 valid; bit13 = slot2 valid; bit12 = slot3 valid; bit11 = slot4 valid.
  - slot1: bit19 = 1 means read, 0 means write; bits[18:12] = register address.
  - slot2: bits[19:4] = write data.
- Commit at bit 255 (the end of a complete frame), only if the valid-frame bit was set:
  - Write: requires slot1 and slot2 valid; updates the register.
  - Read: requires slot1 valid; sets read-pending with the latched address and data.
  - DAC: if the slot3 tag was set, dac_left/dac_right update and dac_valid pulses in the next cycle.
- A frame aborted by an early SYNC rise commits nothing.
- Register file: even addresses only, 64 x 16. Bit 0 of the address is ignored.
  - Defaults: 0x02 = 0x8000, 0x18 = 0x8808, all others 0.
  - 0x26 reads 0x000F in bits [3:0] (read-only), bits [15:4] writable.
  - 0x7C and 0x7E read VENDOR_ID1 and VENDOR_ID2; writes are ignored.
  - A write to 0x00 restores all defaults.
- In-frame (SDATA_IN) encoding:
  - slot0 bit15 = codec_ready.
  - slot0 bits 14/13 = read-pending.
  - slot0 bits 12/11 = codec_ready.
  - slot1 = {1'b0, addr, 12'b0}.
  - slot2 = {data, 4'b0}.
  - slots 3/4 = {adc, 2'b00}.
  - All other bits 0.
- The read response appears in the frame after the command frame. read-pending clears after that frame, unless the same frame commits a new read.
- codec_ready: the frame counter increments on each complete frame, saturating. codec_ready rises with the commit of frame number CODEC_READY_FRAMES.
- Before ready: commands and DAC data are ignored, and the in-frame tag is 0x0000.
- SYNC rise with bit counter < 255 (mid-frame restart): frame_error pulses, the counter restarts at 0, and the partial frame is discarded. codec_ready is unaffected.
- Reset mid-frame: immediate return to the reset state. SDATA_IN = 0 asynchronously.

Test Plan:
- Readiness: after reset, send 4 frames with the valid bit set -> codec_ready = 1 after the 4th frame's bit 255; frame 5 in-tag = 0xF800 (0x9800 when no read is pending).
- Write/read: write 0x02 = 0x1F1F, then read 0x02 -> the following in-frame has slot0 = 0xF800, slot1 = 0x02000, slot2 = 0x1F1F0.
- Read-only/defaults:
  - read 0x7C -> slot2 = 0x4E530;
  - write 0x26 = 0xFFF0, then read -> 0xFFFF0;
  - write 0x00, then read 0x02 -> 0x80000.
- DAC/ADC:
  - out slot3 = 0x12345, slot4 = 0xFFFFF with tags set -> dac_left = 0x048D1, dac_right = 0x3FFFF, dac_valid a single pulse;
  - adc_left = 0x2AAAA -> in slot3 = 0xAAAA8.
- Abort: SYNC rise at bit 100 of a write frame (0x02 = 0x0000) -> frame_error pulse, counter 0, and a later read of 0x02 returns the prior value.
- Reset mid-frame at bit 60 -> SDATA_IN = 0, codec_ready = 0, dac outputs = 0, register 0x02 = 0x8000 after re-ready.
